// File: rtl/cam_pkg.sv
// Shared definitions for the CAM shadow RAM: op encodings, FSM state type and
// the statistics counter width.
package cam_pkg;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_DELETE = 2'b01;
    localparam logic [1:0] OP_FLUSH  = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    localparam int STATS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_ERASE_WAIT = 2'b01,
        ST_FLUSH_SCAN = 2'b10,
        ST_FLUSH_WAIT = 2'b11
    } cam_state_e;

    // Saturating increment shared by the statistics counters.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        logic [STATS_W-1:0] r;
        if (v == {STATS_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(STATS_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/cam_shadow_store.sv
// Shadow storage: data array (not reset) plus per-entry valid bits, with one
// combinational-read/write port and a separate valid-clear port for flushing.
module cam_shadow_store #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic                  i_del,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rvld,
    input  logic                  i_clr_en,
    input  logic [ADDR_WIDTH-1:0] i_clr_addr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_vld;

    // Data array write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Valid bits: set on write, cleared on delete or flush handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= {DEPTH{1'b0}};
        end else begin
            if (i_we) begin
                r_vld[i_addr] <= 1'b1;
            end else if (i_del) begin
                r_vld[i_addr] <= 1'b0;
            end
            if (i_clr_en) begin
                r_vld[i_clr_addr] <= 1'b0;
            end
        end
    end

    assign o_rdata = r_mem[i_addr];
    assign o_rvld  = r_vld[i_addr];

endmodule

// File: rtl/cam_shadow_ram.sv
// CAM shadow RAM: tracks last data per CAM address and issues erase requests
// for stale data. Optional counters enabled by CAM_SHADOW_STATS_EN.
module cam_shadow_ram
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  erase_valid,
    input  logic                  erase_ready,
    output logic [ADDR_WIDTH-1:0] erase_addr,
    output logic [DATA_WIDTH-1:0] erase_data,
    output logic                  busy,
`ifdef CAM_SHADOW_STATS_EN
    output logic [STATS_W-1:0]    erase_count,
    output logic [STATS_W-1:0]    suppress_count,
`endif
    output logic                  flush_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int IDX_W = ADDR_WIDTH + 1;

    cam_state_e            r_state;
    logic                  r_req_ready;
    logic                  r_erase_valid;
    logic [ADDR_WIDTH-1:0] r_erase_addr;
    logic [DATA_WIDTH-1:0] r_erase_data;
    logic                  r_flush_done;
    logic [IDX_W-1:0]      r_idx;

    logic                  w_accept;
    logic                  w_we;
    logic                  w_del;
    logic [ADDR_WIDTH-1:0] w_st_addr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_rvld;
    logic                  w_changed;
    logic                  w_handshake;
    logic                  w_clr_en;
    logic [IDX_W-1:0]      w_idx_next;
    logic                  w_idx_last;

    assign w_accept    = req_valid && r_req_ready && (r_state == ST_IDLE);
    assign w_we        = w_accept && (req_op == OP_WRITE);
    assign w_del       = w_accept && (req_op == OP_DELETE);
    assign w_changed   = (w_rdata != req_data);
    assign w_handshake = r_erase_valid && erase_ready;
    assign w_clr_en    = (r_state == ST_FLUSH_WAIT) && w_handshake;
    assign w_idx_next  = r_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign w_idx_last  = (w_idx_next == IDX_W'(DEPTH));

    // The flush sweep borrows the store port; otherwise it follows the request.
    always_comb begin
        w_st_addr = req_addr;
        if (r_state == ST_FLUSH_SCAN) begin
            w_st_addr = r_idx[ADDR_WIDTH-1:0];
        end else begin
            w_st_addr = req_addr;
        end
    end

    cam_shadow_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_we),
        .i_del      (w_del),
        .i_addr     (w_st_addr),
        .i_wdata    (req_data),
        .o_rdata    (w_rdata),
        .o_rvld     (w_rvld),
        .i_clr_en   (w_clr_en),
        .i_clr_addr (r_erase_addr)
    );

    // Command/erase FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b0;
            r_erase_valid <= 1'b0;
            r_erase_addr  <= {ADDR_WIDTH{1'b0}};
            r_erase_data  <= {DATA_WIDTH{1'b0}};
            r_flush_done  <= 1'b0;
            r_idx         <= {IDX_W{1'b0}};
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        case (req_op)
                            OP_WRITE, OP_DELETE: begin
                                // Identical rewrite must not erase: it would clear the new entry.
                                if (w_rvld && (w_changed || (req_op == OP_DELETE))) begin
                                    r_state       <= ST_ERASE_WAIT;
                                    r_erase_valid <= 1'b1;
                                    r_erase_addr  <= req_addr;
                                    r_erase_data  <= w_rdata;
                                    r_req_ready   <= 1'b0;
                                end
                            end
                            OP_FLUSH: begin
                                r_state     <= ST_FLUSH_SCAN;
                                r_idx       <= {IDX_W{1'b0}};
                                r_req_ready <= 1'b0;
                            end
                            default: begin
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_ERASE_WAIT: begin
                    if (w_handshake) begin
                        r_erase_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                        r_req_ready   <= 1'b1;
                    end
                end
                ST_FLUSH_SCAN: begin
                    if (w_rvld) begin
                        r_state       <= ST_FLUSH_WAIT;
                        r_erase_valid <= 1'b1;
                        r_erase_addr  <= r_idx[ADDR_WIDTH-1:0];
                        r_erase_data  <= w_rdata;
                    end else if (w_idx_last) begin
                        r_state      <= ST_IDLE;
                        r_flush_done <= 1'b1;
                        r_req_ready  <= 1'b1;
                    end else begin
                        r_idx <= w_idx_next;
                    end
                end
                ST_FLUSH_WAIT: begin
                    if (w_handshake) begin
                        r_erase_valid <= 1'b0;
                        if (w_idx_last) begin
                            r_state      <= ST_IDLE;
                            r_flush_done <= 1'b1;
                            r_req_ready  <= 1'b1;
                        end else begin
                            r_idx   <= w_idx_next;
                            r_state <= ST_FLUSH_SCAN;
                        end
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_erase_valid <= 1'b0;
                    r_req_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign erase_valid = r_erase_valid;
    assign erase_addr  = r_erase_addr;
    assign erase_data  = r_erase_data;
    assign flush_done  = r_flush_done;
    assign busy        = (r_state != ST_IDLE);

`ifdef CAM_SHADOW_STATS_EN
    logic [STATS_W-1:0] r_erase_count;
    logic [STATS_W-1:0] r_suppress_count;
    logic               w_suppress;

    assign w_suppress = w_we && w_rvld && !w_changed;

    // Saturating counts of completed erases and suppressed identical rewrites.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_erase_count    <= {STATS_W{1'b0}};
            r_suppress_count <= {STATS_W{1'b0}};
        end else begin
            if (w_handshake) begin
                r_erase_count <= sat_inc(r_erase_count);
            end
            if (w_suppress) begin
                r_suppress_count <= sat_inc(r_suppress_count);
            end
        end
    end

    assign erase_count    = r_erase_count;
    assign suppress_count = r_suppress_count;
`endif

endmodule

// File: tb/tb_cam_shadow_ram.sv
// Self-checking bench for cam_shadow_ram: directed vector table, hand-written
// stall/flush/reset sequences, then randomized commands against a shadow model.
module tb_cam_shadow_ram;
    import cam_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = OP_NOP;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          erase_valid;
    logic          erase_ready = 1'b0;
    logic [AW-1:0] erase_addr;
    logic [DW-1:0] erase_data;
    logic          busy;
    logic          flush_done;
`ifdef CAM_SHADOW_STATS_EN
    logic [15:0]   erase_count;
    logic [15:0]   suppress_count;
`endif

    always #5 clk = ~clk;

    cam_shadow_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .erase_valid    (erase_valid),
        .erase_ready    (erase_ready),
        .erase_addr     (erase_addr),
        .erase_data     (erase_data),
        .busy           (busy),
`ifdef CAM_SHADOW_STATS_EN
        .erase_count    (erase_count),
        .suppress_count (suppress_count),
`endif
        .flush_done     (flush_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: contents, valid flags and expected erase stream.
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } er_t;
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_vld [DEPTH];
    er_t           exp_q [$];
    int            m_erases   = 0;
    int            m_suppress = 0;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        exp_q.delete();
        m_erases   = 0;
        m_suppress = 0;
    endfunction

    function automatic void model_apply(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        er_t e;
        case (op)
            OP_WRITE: begin
                if (m_vld[a] && m_mem[a] != d) begin
                    e.a = a; e.d = m_mem[a]; exp_q.push_back(e);
                end else if (m_vld[a]) begin
                    m_suppress++;
                end
                m_mem[a] = d;
                m_vld[a] = 1'b1;
            end
            OP_DELETE: begin
                if (m_vld[a]) begin
                    e.a = a; e.d = m_mem[a]; exp_q.push_back(e);
                end
                m_vld[a] = 1'b0;
            end
            OP_FLUSH: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (m_vld[i]) begin
                        e.a = AW'(i); e.d = m_mem[i]; exp_q.push_back(e);
                        m_vld[i] = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (!req_ready) chk("req_ready_wait", req_ready, 1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_ready();
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        model_apply(op, a, d);
        step();
        req_valid = 1'b0;
        req_op    = OP_NOP;
    endtask

    // Issue one command and check the erase stream against the model until idle.
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int rdy_pct, output int busy_cycles);
        int fd;
        busy_cycles = 0;
        fd = 0;
        issue(op, a, d);
        for (int c = 0; c < 200; c++) begin
            if (flush_done) fd++;
            if (!busy) break;
            busy_cycles++;
            erase_ready = ($urandom_range(0, 99) < rdy_pct);
            if (erase_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_erase", erase_valid, 0);
                end else begin
                    chk("erase_addr", erase_addr, exp_q[0].a);
                    chk("erase_data", erase_data, exp_q[0].d);
                    if (erase_ready) begin
                        void'(exp_q.pop_front());
                        m_erases++;
                    end
                end
            end
            step();
        end
        erase_ready = 1'b0;
        chk("cmd_idle", busy, 0);
        chk("erase_q_drained", exp_q.size(), 0);
        chk("flush_done_pulses", fd, (op == OP_FLUSH) ? 1 : 0);
        exp_q.delete();
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            ev;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
    } vec_t;
    vec_t tbl [10];

    initial begin
        int bc;
        logic [1:0] rop;
        int sel;

        tbl[0] = '{OP_WRITE,  2'd1, 8'hA5, 1'b0, 2'd0, 8'h00};
        tbl[1] = '{OP_WRITE,  2'd1, 8'h3C, 1'b1, 2'd1, 8'hA5};
        tbl[2] = '{OP_WRITE,  2'd2, 8'h11, 1'b0, 2'd0, 8'h00};
        tbl[3] = '{OP_WRITE,  2'd2, 8'h11, 1'b0, 2'd0, 8'h00};
        tbl[4] = '{OP_DELETE, 2'd3, 8'h00, 1'b0, 2'd0, 8'h00};
        tbl[5] = '{OP_DELETE, 2'd2, 8'h00, 1'b1, 2'd2, 8'h11};
        tbl[6] = '{OP_WRITE,  2'd2, 8'h55, 1'b0, 2'd0, 8'h00};
        tbl[7] = '{OP_NOP,    2'd0, 8'h00, 1'b0, 2'd0, 8'h00};
        tbl[8] = '{OP_WRITE,  2'd1, 8'h3C, 1'b0, 2'd0, 8'h00};
        tbl[9] = '{OP_DELETE, 2'd1, 8'h00, 1'b1, 2'd1, 8'h3C};

        model_reset();
        #12;
        chk("rst_erase_valid", erase_valid, 0);
        chk("rst_erase_addr", erase_addr, 0);
        chk("rst_erase_data", erase_data, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("ready_after_reset", req_ready, 1);

        // Directed vector table, zero-wait CAM.
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].d);
            chk("tbl_erase_valid", erase_valid, tbl[i].ev);
            chk("tbl_req_ready", req_ready, !tbl[i].ev);
            if (tbl[i].ev) begin
                chk("tbl_erase_addr", erase_addr, tbl[i].ea);
                chk("tbl_erase_data", erase_data, tbl[i].ed);
                erase_ready = 1'b1;
                step();
                erase_ready = 1'b0;
                m_erases++;
            end
            chk("tbl_release_ready", req_ready, 1);
            chk("tbl_release_busy", busy, 0);
            exp_q.delete();
        end
`ifdef CAM_SHADOW_STATS_EN
        chk("suppress_count_tbl", suppress_count, 2);
`endif

        // Back-pressured erase: outputs hold for three stalled cycles.
        run_cmd(OP_WRITE, 2'd0, 8'h77, 100, bc);
        issue(OP_WRITE, 2'd0, 8'h88);
        for (int k = 0; k < 3; k++) begin
            chk("stall_erase_valid", erase_valid, 1);
            chk("stall_erase_addr", erase_addr, 0);
            chk("stall_erase_data", erase_data, 8'h77);
            chk("stall_req_ready", req_ready, 0);
            step();
        end
        erase_ready = 1'b1;
        chk("stall_last_valid", erase_valid, 1);
        step();
        erase_ready = 1'b0;
        m_erases++;
        exp_q.delete();
        chk("stall_release_valid", erase_valid, 0);
        chk("stall_release_ready", req_ready, 1);
        chk("stall_release_busy", busy, 0);

        // Flush with entries at 0 and 3, then an empty flush.
        run_cmd(OP_DELETE, 2'd2, 8'h00, 100, bc);
        run_cmd(OP_WRITE, 2'd0, 8'h01, 100, bc);
        run_cmd(OP_WRITE, 2'd3, 8'h04, 100, bc);
        run_cmd(OP_FLUSH, 2'd0, 8'h00, 100, bc);
        chk("flush_busy_cycles", bc, 6);
        step();
        chk("flush_done_one_cycle", flush_done, 0);
        run_cmd(OP_FLUSH, 2'd2, 8'h00, 100, bc);
        chk("empty_flush_cycles", bc, DEPTH);
        run_cmd(OP_WRITE, 2'd0, 8'h01, 100, bc);
        chk("write_after_flush_cycles", bc, 0);

        // Reset while an erase is pending.
        run_cmd(OP_WRITE, 2'd1, 8'hAA, 100, bc);
        issue(OP_WRITE, 2'd1, 8'hBB);
        chk("pre_reset_erase_valid", erase_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_erase_valid", erase_valid, 0);
        chk("async_reset_busy", busy, 0);
`ifdef CAM_SHADOW_STATS_EN
        chk("reset_erase_count", erase_count, 0);
        chk("reset_suppress_count", suppress_count, 0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        run_cmd(OP_WRITE, 2'd1, 8'hCC, 100, bc);
        chk("write_after_reset_cycles", bc, 0);

        // Randomized commands against the model.
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)       rop = OP_WRITE;
            else if (sel < 8)  rop = OP_DELETE;
            else if (sel == 8) rop = OP_FLUSH;
            else               rop = OP_NOP;
            run_cmd(rop, AW'($urandom_range(0, DEPTH-1)), DW'($urandom_range(0, 3)),
                    $urandom_range(30, 100), bc);
        end
`ifdef CAM_SHADOW_STATS_EN
        chk("final_erase_count", erase_count, m_erases);
        chk("final_suppress_count", suppress_count, m_suppress);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
